// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA job sequencer.
// Optional key cache is enabled with the macro RSA_SEQ_KEY_CACHE_EN.
package rsa_pkg;

    localparam int unsigned RSA_WIDTH       = 128;
    localparam int unsigned RSA_CNT_W       = 32;
    localparam int unsigned RSA_TIMEOUT_CYC = 32'd1 << 24;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INV_PULSE = 3'd1,
        S_INV_WAIT  = 3'd2,
        S_EXP_PULSE = 3'd3,
        S_EXP_WAIT  = 3'd4,
        S_RESP      = 3'd5
    } seq_state_e;

    // States in which the job cycle counter advances.
    function automatic logic seq_is_busy(input seq_state_e s);
        return (s == S_INV_PULSE) || (s == S_INV_WAIT) ||
               (s == S_EXP_PULSE) || (s == S_EXP_WAIT);
    endfunction

endpackage

// File: rtl/rsa_seq_watchdog.sv
// Clearable wait-state counter with a registered terminal-count flag.
// term_o is high during the LIMIT-th counted cycle after a clear.
module rsa_seq_watchdog #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          term_q, term_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !term_q) begin
            cnt_d = cnt_q + CW'(1);
        end
        term_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            term_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign term_o = term_q;

endmodule

// File: rtl/rsa_job_sequencer.sv
// Job front-end for the RSA control core: two-phase start protocol, watchdog, response port.
// Define RSA_SEQ_KEY_CACHE_EN to skip the inverter phase for a repeated (p, q, mode).
module rsa_job_sequencer
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH       = RSA_WIDTH,
    parameter int unsigned CNT_W       = RSA_CNT_W,
    parameter int unsigned TIMEOUT_CYC = RSA_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_p,
    input  logic [WIDTH-1:0]     req_q,
    input  logic                 req_mode,
    input  logic [2*WIDTH-1:0]   req_msg,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_msg,
    output logic                 rsp_err,
    output logic [CNT_W-1:0]     rsp_cycles,
    output logic [WIDTH-1:0]     core_p,
    output logic [WIDTH-1:0]     core_q,
    output logic                 core_mode,
    output logic [2*WIDTH-1:0]   core_msg,
    output logic                 core_reset_inverter,
    output logic                 core_reset_mod_exp,
    input  logic                 core_inverter_finish,
    input  logic                 core_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   core_msg_out
);

    seq_state_e             state_q, state_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]     rsp_msg_q, rsp_msg_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]       rsp_cyc_q, rsp_cyc_d;
    logic [CNT_W-1:0]       cyc_q, cyc_d, cyc_inc;
    logic [WIDTH-1:0]       cp_q, cp_d, cq_q, cq_d;
    logic                   cmode_q, cmode_d;
    logic [2*WIDTH-1:0]     cmsg_q, cmsg_d;
    logic                   pinv_q, pinv_d, pexp_q, pexp_d;
    logic                   wd_clr_c, wd_inc_c, wd_term;

`ifdef RSA_SEQ_KEY_CACHE_EN
    logic                   key_vld_q, key_vld_d;
    logic [WIDTH-1:0]       key_p_q, key_p_d, key_q_q, key_q_d;
    logic                   key_mode_q, key_mode_d;
    logic                   key_hit_c;

    assign key_hit_c = key_vld_q && (key_p_q == req_p) && (key_q_q == req_q) &&
                       (key_mode_q == req_mode);
`endif

    rsa_seq_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (wd_clr_c),
        .inc_i  (wd_inc_c),
        .term_o (wd_term)
    );

    // Accept cycle is loaded as 1, so rsp_cycles includes it.
    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        rsp_msg_d = rsp_msg_q;
        rsp_err_d = rsp_err_q;
        rsp_cyc_d = rsp_cyc_q;
        cyc_d     = cyc_q;
        cp_d      = cp_q;
        cq_d      = cq_q;
        cmode_d   = cmode_q;
        cmsg_d    = cmsg_q;
        wd_clr_c  = 1'b0;
        wd_inc_c  = 1'b0;
`ifdef RSA_SEQ_KEY_CACHE_EN
        key_vld_d  = key_vld_q;
        key_p_d    = key_p_q;
        key_q_d    = key_q_q;
        key_mode_d = key_mode_q;
`endif
        if (seq_is_busy(state_q)) begin
            cyc_d = cyc_inc;
        end

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cp_d    = req_p;
                    cq_d    = req_q;
                    cmode_d = req_mode;
                    cmsg_d  = req_msg;
                    cyc_d   = CNT_W'(1);
                    state_d = S_INV_PULSE;
`ifdef RSA_SEQ_KEY_CACHE_EN
                    if (key_hit_c) begin
                        state_d = S_EXP_PULSE;
                    end
`endif
                end
            end
            S_INV_PULSE: begin
                wd_clr_c = 1'b1;
                state_d  = S_INV_WAIT;
            end
            S_INV_WAIT: begin
                wd_inc_c = 1'b1;
                if (core_inverter_finish) begin
                    state_d = S_EXP_PULSE;
                end else if (wd_term) begin
                    rsp_err_d = 1'b1;
                    rsp_msg_d = '0;
                    rsp_cyc_d = cyc_inc;
                    state_d   = S_RESP;
`ifdef RSA_SEQ_KEY_CACHE_EN
                    key_vld_d = 1'b0;
`endif
                end
            end
            S_EXP_PULSE: begin
                wd_clr_c = 1'b1;
                state_d  = S_EXP_WAIT;
            end
            S_EXP_WAIT: begin
                wd_inc_c = 1'b1;
                if (core_mod_exp_finish) begin
                    rsp_err_d = 1'b0;
                    rsp_msg_d = core_msg_out;
                    rsp_cyc_d = cyc_inc;
                    state_d   = S_RESP;
`ifdef RSA_SEQ_KEY_CACHE_EN
                    key_vld_d  = 1'b1;
                    key_p_d    = cp_q;
                    key_q_d    = cq_q;
                    key_mode_d = cmode_q;
`endif
                end else if (wd_term) begin
                    rsp_err_d = 1'b1;
                    rsp_msg_d = '0;
                    rsp_cyc_d = cyc_inc;
                    state_d   = S_RESP;
`ifdef RSA_SEQ_KEY_CACHE_EN
                    key_vld_d = 1'b0;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        pinv_d      = (state_d == S_INV_PULSE);
        pexp_d      = (state_d == S_EXP_PULSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_msg_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_cyc_q   <= '0;
            cyc_q       <= '0;
            cp_q        <= '0;
            cq_q        <= '0;
            cmode_q     <= 1'b0;
            cmsg_q      <= '0;
            pinv_q      <= 1'b0;
            pexp_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_msg_q   <= rsp_msg_d;
            rsp_err_q   <= rsp_err_d;
            rsp_cyc_q   <= rsp_cyc_d;
            cyc_q       <= cyc_d;
            cp_q        <= cp_d;
            cq_q        <= cq_d;
            cmode_q     <= cmode_d;
            cmsg_q      <= cmsg_d;
            pinv_q      <= pinv_d;
            pexp_q      <= pexp_d;
        end
    end

`ifdef RSA_SEQ_KEY_CACHE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            key_vld_q  <= 1'b0;
            key_p_q    <= '0;
            key_q_q    <= '0;
            key_mode_q <= 1'b0;
        end else begin
            key_vld_q  <= key_vld_d;
            key_p_q    <= key_p_d;
            key_q_q    <= key_q_d;
            key_mode_q <= key_mode_d;
        end
    end
`endif

    assign req_ready           = req_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_msg             = rsp_msg_q;
    assign rsp_err             = rsp_err_q;
    assign rsp_cycles          = rsp_cyc_q;
    assign core_p              = cp_q;
    assign core_q              = cq_q;
    assign core_mode           = cmode_q;
    assign core_msg            = cmsg_q;
    assign core_reset_inverter = pinv_q;
    assign core_reset_mod_exp  = pexp_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Directed bench for rsa_job_sequencer with a stub core (finish 3 cycles after each pulse).
// Stub result: encrypt = msg + {p,q}, decrypt = msg - {p,q}, so chained jobs round-trip.
module tb_rsa_job_sequencer;

    localparam int unsigned W  = 128;
    localparam int unsigned CW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid, req_ready, req_mode;
    logic [W-1:0]    req_p, req_q;
    logic [2*W-1:0]  req_msg;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [2*W-1:0]  rsp_msg;
    logic [CW-1:0]   rsp_cycles;
    logic [W-1:0]    core_p, core_q;
    logic            core_mode;
    logic [2*W-1:0]  core_msg, core_msg_out;
    logic            core_reset_inverter, core_reset_mod_exp;
    logic            core_inverter_finish, core_mod_exp_finish;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rsa_job_sequencer #(.WIDTH(W), .CNT_W(CW), .TIMEOUT_CYC(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_p                (req_p),
        .req_q                (req_q),
        .req_mode             (req_mode),
        .req_msg              (req_msg),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_msg              (rsp_msg),
        .rsp_err              (rsp_err),
        .rsp_cycles           (rsp_cycles),
        .core_p               (core_p),
        .core_q               (core_q),
        .core_mode            (core_mode),
        .core_msg             (core_msg),
        .core_reset_inverter  (core_reset_inverter),
        .core_reset_mod_exp   (core_reset_mod_exp),
        .core_inverter_finish (core_inverter_finish),
        .core_mod_exp_finish  (core_mod_exp_finish),
        .core_msg_out         (core_msg_out)
    );

    // Stub core: finish rises in the 4th cycle after the pulse is sampled, holds until next pulse.
    logic           stub_inv_en, stub_hold;
    logic           inv_fin_q, exp_fin_q;
    int unsigned    inv_cnt_q, exp_cnt_q;
    logic [2*W-1:0] stub_out_q;
    int             inv_pulses, exp_pulses;

    always_ff @(posedge clk) begin
        if (reset) begin
            inv_fin_q  <= 1'b0;
            exp_fin_q  <= 1'b0;
            inv_cnt_q  <= 0;
            exp_cnt_q  <= 0;
            stub_out_q <= '0;
            inv_pulses <= 0;
            exp_pulses <= 0;
        end else begin
            if (core_reset_inverter) begin
                inv_cnt_q  <= 3;
                inv_fin_q  <= 1'b0;
                inv_pulses <= inv_pulses + 1;
            end else if (inv_cnt_q != 0) begin
                inv_cnt_q <= inv_cnt_q - 1;
                if (inv_cnt_q == 1 && stub_inv_en) inv_fin_q <= 1'b1;
            end
            if (core_reset_mod_exp) begin
                exp_cnt_q  <= 3;
                exp_fin_q  <= 1'b0;
                exp_pulses <= exp_pulses + 1;
                stub_out_q <= core_mode ? core_msg - {core_p, core_q} : core_msg + {core_p, core_q};
            end else if (exp_cnt_q != 0) begin
                exp_cnt_q <= exp_cnt_q - 1;
                if (exp_cnt_q == 1) exp_fin_q <= 1'b1;
            end
        end
    end

    assign core_inverter_finish = inv_fin_q | stub_hold;
    assign core_mod_exp_finish  = exp_fin_q | stub_hold;
    assign core_msg_out         = stub_out_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency counts the accept cycle as cycle 1; -1 means no response within budget.
    task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic mode,
                           input logic [2*W-1:0] msg, output int lat, output int dinv,
                           output int dexp);
        int inv0, exp0, n;
        inv0 = inv_pulses;
        exp0 = exp_pulses;
        req_p = p; req_q = q; req_mode = mode; req_msg = msg; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        lat  = rsp_valid ? n + 1 : -1;
        dinv = inv_pulses - inv0;
        dexp = exp_pulses - exp0;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_mode = 1'b0;
        req_p = '0; req_q = '0; req_msg = '0; stub_inv_en = 1'b1; stub_hold = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0 || rsp_msg !== '0 || rsp_cycles !== '0) begin
            errors++; $display("FAIL reset_rsp got err=%b msg=%h cyc=%0d exp 0/0/0", rsp_err, rsp_msg, rsp_cycles); end
        checks++; if (core_p !== '0 || core_q !== '0 || core_msg !== '0 || core_mode !== 1'b0) begin
            errors++; $display("FAIL reset_core_data got p=%h q=%h msg=%h exp 0", core_p, core_q, core_msg); end
        checks++; if (core_reset_inverter !== 1'b0 || core_reset_mod_exp !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got inv=%b exp=%b exp 0/0", core_reset_inverter, core_reset_mod_exp); end
    endtask

    task automatic test_stub_job();
        int lat, di, de;
        logic [2*W-1:0] expv;
        expv = 256'd65 + {128'd61, 128'd53};
        run_job(128'd61, 128'd53, 1'b0, 256'd65, lat, di, de);
        checks++; if (lat != 11) begin errors++; $display("FAIL stub_latency got %0d exp 11", lat); end
        checks++; if (di != 1 || de != 1) begin errors++; $display("FAIL stub_pulses got inv=%0d exp=%0d exp 1/1", di, de); end
        checks++; if (rsp_msg !== expv || rsp_err !== 1'b0) begin
            errors++; $display("FAIL stub_result got %h err=%b exp %h err=0", rsp_msg, rsp_err, expv); end
        checks++; if (rsp_cycles !== 32'd11) begin errors++; $display("FAIL stub_cycles got %0d exp 11", rsp_cycles); end
        ack();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL stub_handshake got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
        checks++; if (core_p !== 128'd61 || core_q !== 128'd53 || core_msg !== 256'd65) begin
            errors++; $display("FAIL stub_core_held got p=%0d q=%0d msg=%0d exp 61/53/65", core_p, core_q, core_msg); end
    endtask

    task automatic test_chain();
        int lat, di, de;
        logic [W-1:0]   p, q;
        logic [2*W-1:0] m, enc;
        p = 128'd113680897410347;
        q = 128'd7999808077935876437321;
        m = 256'hf03ab37b0000000000;
        run_job(p, q, 1'b0, m, lat, di, de);
        enc = rsp_msg;
        checks++; if (lat != 11 || enc !== m + {p, q}) begin
            errors++; $display("FAIL chain_encrypt got lat=%0d msg=%h exp 11/%h", lat, enc, m + {p, q}); end
        checks++; if (core_mode !== 1'b0) begin errors++; $display("FAIL chain_mode_enc got %b exp 0", core_mode); end
        ack();
        run_job(p, q, 1'b1, enc, lat, di, de);
        checks++; if (rsp_msg !== m || rsp_err !== 1'b0) begin
            errors++; $display("FAIL chain_decrypt got %h err=%b exp %h err=0", rsp_msg, rsp_err, m); end
        checks++; if (di != 1 || core_mode !== 1'b1) begin
            errors++; $display("FAIL chain_dec_inv got inv=%0d mode=%b exp 1/1", di, core_mode); end
        ack();
    endtask

    task automatic test_stale_finish();
        int lat, di, de;
        stub_hold = 1'b1;
        run_job(128'd7, 128'd11, 1'b0, 256'd100, lat, di, de);
        checks++; if (lat != 5) begin errors++; $display("FAIL stale_latency got %0d exp 5", lat); end
        checks++; if (rsp_cycles !== 32'd5) begin errors++; $display("FAIL stale_cycles got %0d exp 5", rsp_cycles); end
        checks++; if (di != 1 || de != 1) begin errors++; $display("FAIL stale_pulses got inv=%0d exp=%0d exp 1/1", di, de); end
        ack();
        stub_hold = 1'b0;
    endtask

    task automatic test_timeout();
        int lat, di, de;
        stub_inv_en = 1'b0;
        run_job(128'd3, 128'd5, 1'b0, 256'd9, lat, di, de);
        checks++; if (rsp_err !== 1'b1 || rsp_msg !== '0) begin
            errors++; $display("FAIL timeout_result got err=%b msg=%h exp 1/0", rsp_err, rsp_msg); end
        checks++; if (di != 1 || de != 0) begin errors++; $display("FAIL timeout_pulses got inv=%0d exp=%0d exp 1/0", di, de); end
        checks++; if (lat != 18 || rsp_cycles !== 32'd18) begin
            errors++; $display("FAIL timeout_cycles got lat=%0d cyc=%0d exp 18/18", lat, rsp_cycles); end
        ack();
        stub_inv_en = 1'b1;
    endtask

    task automatic test_backpressure();
        int lat, di, de, bad;
        logic [2*W-1:0] expv;
        expv = 256'h1234 + {128'd17, 128'd19};
        run_job(128'd17, 128'd19, 1'b0, 256'h1234, lat, di, de);
        checks++; if (lat != 11) begin errors++; $display("FAIL bp_latency got %0d exp 11", lat); end
        req_p = 128'd99; req_q = 128'd99; req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_msg !== expv || req_ready !== 1'b0 || rsp_cycles !== 32'd11) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles exp 0", bad); end
        ack();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || core_p !== 128'd17) begin
            errors++; $display("FAIL bp_release got valid=%b ready=%b p=%0d exp 0/1/17", rsp_valid, req_ready, core_p); end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        int e0;
        req_p = 128'd23; req_q = 128'd29; req_mode = 1'b0; req_msg = 256'd5; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (7) tick();
        checks++; if (core_p !== 128'd23 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_before got p=%0d valid=%b exp 23/0", core_p, rsp_valid); end
        reset = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_msg !== '0 || rsp_cycles !== '0) begin
            errors++; $display("FAIL midrst_rsp got ready=%b valid=%b msg=%h cyc=%0d exp 1/0/0/0",
                               req_ready, rsp_valid, rsp_msg, rsp_cycles); end
        checks++; if (core_p !== '0 || core_msg !== '0 || core_reset_mod_exp !== 1'b0 || core_reset_inverter !== 1'b0) begin
            errors++; $display("FAIL midrst_core got p=%h msg=%h pexp=%b exp 0", core_p, core_msg, core_reset_mod_exp); end
        reset = 1'b0;
        tick();
        e0 = exp_pulses;
        repeat (10) tick();
        checks++; if (exp_pulses != e0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet got pulses=%0d valid=%b exp 0/0", exp_pulses - e0, rsp_valid); end
    endtask

    task automatic test_key_cache();
        int lat, di, de;
        run_job(128'd61, 128'd53, 1'b0, 256'd65, lat, di, de);
        checks++; if (di != 1 || rsp_cycles !== 32'd11) begin
            errors++; $display("FAIL cache_first got inv=%0d cyc=%0d exp 1/11", di, rsp_cycles); end
        ack();
        run_job(128'd61, 128'd53, 1'b0, 256'd66, lat, di, de);
`ifdef RSA_SEQ_KEY_CACHE_EN
        checks++; if (di != 0 || de != 1 || rsp_cycles !== 32'd6 || lat != 6) begin
            errors++; $display("FAIL cache_hit got inv=%0d exp=%0d cyc=%0d lat=%0d exp 0/1/6/6", di, de, rsp_cycles, lat); end
`else
        checks++; if (di != 1 || de != 1 || rsp_cycles !== 32'd11 || lat != 11) begin
            errors++; $display("FAIL nocache_repeat got inv=%0d exp=%0d cyc=%0d lat=%0d exp 1/1/11/11", di, de, rsp_cycles, lat); end
`endif
        checks++; if (rsp_msg !== 256'd66 + {128'd61, 128'd53}) begin
            errors++; $display("FAIL cache_result got %h exp %h", rsp_msg, 256'd66 + {128'd61, 128'd53}); end
        ack();
        run_job(128'd61, 128'd59, 1'b0, 256'd66, lat, di, de);
        checks++; if (di != 1 || rsp_cycles !== 32'd11) begin
            errors++; $display("FAIL cache_newkey got inv=%0d cyc=%0d exp 1/11", di, rsp_cycles); end
        ack();
    endtask

    initial begin
        test_reset();
        test_stub_job();
        test_chain();
        test_stale_finish();
        test_timeout();
        test_backpressure();
        test_reset_mid_job();
        test_key_cache();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
